axi_line_fill_master: RTL and testbench

AXI4 burst-read initiator that fetches one whole cache line per request on behalf of the Enokida n-way cache. It sits between the cache's miss handler and the instruction or data memory AXI interconnect, and drives the AR/R channels that the memory slave answers. Each request produces one INCR burst of `LINE_WORDS` beats. The beats are assembled into a single line-wide response with an error flag.

---
 rtl/enokida_axi_pkg.sv | 20 ++
 rtl/axi_line_fill_master.sv | 98 +++++++++
 tb/tb_axi_line_fill_master.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/enokida_axi_pkg.sv
// Shared AXI encodings and fill-engine state type for the Enokida cache masters.
package enokida_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_ADDR,
        FILL_DATA,
        FILL_DONE
    } fill_state_t;

endpackage

// File: rtl/axi_line_fill_master.sv
// AXI4 burst-read initiator: fetches one cache line per request as a single INCR burst
// and returns it as one line-wide response with an error flag.
module axi_line_fill_master
    import enokida_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             resp_valid,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rdata,
    output logic                             resp_err,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                       m_axi_rresp,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready
);

    localparam int OFF_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int CNT_W    = $clog2(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    fill_state_t state, state_nxt;

    logic [CNT_W-1:0]                       beat_cnt;
    logic                                   err_q;
    logic [ADDR_WIDTH-1:0]                  addr_q;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]  line_q;
    logic                                   beat;
    logic                                   last_beat;

    assign beat      = (state == FILL_DATA) && m_axi_rvalid;
    assign last_beat = (beat_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL_IDLE;
        else        state <= state_nxt;
    end

    // Burst ends on beat count alone; a misplaced RLAST only raises the error flag.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL_IDLE: if (req_valid)            state_nxt = FILL_ADDR;
            FILL_ADDR: if (m_axi_arready)        state_nxt = FILL_DATA;
            FILL_DATA: if (beat && last_beat)    state_nxt = FILL_DONE;
            FILL_DONE:                           state_nxt = FILL_IDLE;
            default:                             state_nxt = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            line_q   <= '0;
        end else begin
            if (state == FILL_IDLE && req_valid) begin
                addr_q   <= req_addr & LINE_MASK;
                beat_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (beat) begin
                line_q[beat_cnt] <= m_axi_rdata;
                beat_cnt         <= beat_cnt + CNT_W'(1);
                if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != last_beat)
                    err_q <= 1'b1;
            end
        end
    end

    assign req_ready     = (state == FILL_IDLE);
    assign m_axi_arvalid = (state == FILL_ADDR);
    assign m_axi_rready  = (state == FILL_DATA);
    assign resp_valid    = (state == FILL_DONE);
    assign resp_err      = err_q;
    assign resp_rdata    = line_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_line_fill_master.sv
// Bench for axi_line_fill_master: table of directed fills, randomized fills against a
// line-level reference model, plus reset-mid-burst and back-to-back request sequences.
module tb_axi_line_fill_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              req_valid = 0;
    logic              req_ready;
    logic [AW-1:0]     req_addr = '0;
    logic              resp_valid;
    logic [LW*DW-1:0]  resp_rdata;
    logic              resp_err;
    logic [AW-1:0]     m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready = 0;
    logic [DW-1:0]     m_axi_rdata = '0;
    logic [1:0]        m_axi_rresp = '0;
    logic              m_axi_rlast = 0;
    logic              m_axi_rvalid = 0;
    logic              m_axi_rready;

    axi_line_fill_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]          addr;
        logic [LW-1:0][DW-1:0]  data;
        logic [LW-1:0][1:0]     resp;
        logic [LW-1:0]          last;
        int                     ar_dly;
        int                     gap;
        logic [AW-1:0]          exp_araddr;
        logic [LW*DW-1:0]       exp_line;
        logic                   exp_err;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [LW*DW-1:0] act, input logic [LW*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference: a 16-byte line at the aligned address, words packed in beat order,
    // error if any beat is not OKAY or RLAST is anywhere but the final beat.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_araddr = {v.addr[AW-1:4], 4'h0};
        r.exp_err = 1'b0;
        for (int b = 0; b < LW; b++) begin
            r.exp_line[b*DW +: DW] = v.data[b];
            if (v.resp[b] != 2'b00) r.exp_err = 1'b1;
            if (v.last[b] != (b == LW-1)) r.exp_err = 1'b1;
        end
        return r;
    endfunction

    task automatic do_fill(input vec_t v, input bit pre_acc, input bit hold, input logic [AW-1:0] next_addr);
        if (!pre_acc) begin
            @(negedge clk);
            chk("req_ready_idle", 128'(req_ready), 128'(1));
            req_valid = 1; req_addr = v.addr;
            @(negedge clk);
            req_valid = hold;
            if (hold) req_addr = next_addr;
        end
        chk("arvalid_rise", 128'(m_axi_arvalid), 128'(1));
        chk("araddr", 128'(m_axi_araddr), 128'(v.exp_araddr));
        chk("arlen", 128'(m_axi_arlen), 128'(3));
        chk("arsize", 128'(m_axi_arsize), 128'(2));
        chk("arburst", 128'(m_axi_arburst), 128'(1));
        chk("req_ready_busy", 128'(req_ready), 128'(0));
        repeat (v.ar_dly) begin
            m_axi_arready = 0;
            @(negedge clk);
            chk("arvalid_hold", 128'(m_axi_arvalid), 128'(1));
            chk("araddr_hold", 128'(m_axi_araddr), 128'(v.exp_araddr));
        end
        m_axi_arready = 1;
        @(negedge clk);
        m_axi_arready = 0;
        chk("arvalid_drop", 128'(m_axi_arvalid), 128'(0));
        chk("rready_rise", 128'(m_axi_rready), 128'(1));
        for (int b = 0; b < LW; b++) begin
            repeat (v.gap) begin
                m_axi_rvalid = 0; m_axi_rdata = $urandom;
                @(negedge clk);
                chk("resp_in_gap", 128'(resp_valid), 128'(0));
            end
            m_axi_rvalid = 1; m_axi_rdata = v.data[b];
            m_axi_rresp = v.resp[b]; m_axi_rlast = v.last[b];
            @(negedge clk);
            m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
            if (b < LW-1) chk("resp_early", 128'(resp_valid), 128'(0));
        end
        chk("resp_valid", 128'(resp_valid), 128'(1));
        chk("resp_rdata", resp_rdata, v.exp_line);
        chk("resp_err", 128'(resp_err), 128'(v.exp_err));
        @(negedge clk);
        chk("resp_pulse_end", 128'(resp_valid), 128'(0));
        chk("req_ready_back", 128'(req_ready), 128'(1));
        chk("rdata_stable", resp_rdata, v.exp_line);
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        // basic, backpressure, slave error, misplaced rlast, clean fill at 0x40
        tbl[0] = '{addr:32'h0000_1234, data:{32'h44, 32'h33, 32'h22, 32'h11}, resp:'0, last:4'b1000,
                   ar_dly:0, gap:0, exp_araddr:32'h0000_1230,
                   exp_line:128'h00000044_00000033_00000022_00000011, exp_err:1'b0};
        tbl[1] = '{addr:32'h0000_1234, data:{32'h44, 32'h33, 32'h22, 32'h11}, resp:'0, last:4'b1000,
                   ar_dly:5, gap:2, exp_araddr:32'h0000_1230,
                   exp_line:128'h00000044_00000033_00000022_00000011, exp_err:1'b0};
        tbl[2] = '{addr:32'h0000_2008, data:{32'hD4, 32'hC3, 32'hB2, 32'hA1}, resp:{2'b00, 2'b10, 2'b00, 2'b00},
                   last:4'b1000, ar_dly:1, gap:0, exp_araddr:32'h0000_2000,
                   exp_line:128'h000000D4_000000C3_000000B2_000000A1, exp_err:1'b1};
        tbl[3] = '{addr:32'h0000_300F, data:{32'h4, 32'h3, 32'h2, 32'h1}, resp:'0, last:4'b0010,
                   ar_dly:0, gap:1, exp_araddr:32'h0000_3000,
                   exp_line:128'h00000004_00000003_00000002_00000001, exp_err:1'b1};
        tbl[4] = '{addr:32'h0000_0040, data:{32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000},
                   resp:'0, last:4'b1000, ar_dly:0, gap:0, exp_araddr:32'h0000_0040,
                   exp_line:128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, exp_err:1'b0};

        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(1));
        chk("rst_arvalid", 128'(m_axi_arvalid), 128'(0));
        chk("rst_rready", 128'(m_axi_rready), 128'(0));
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_resp_err", 128'(resp_err), 128'(0));
        chk("rst_araddr", 128'(m_axi_araddr), 128'(0));
        chk("rst_rdata", resp_rdata, 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 4; i++) do_fill(tbl[i], 0, 0, '0);

        // reset after two beats: everything back to reset values at once
        @(negedge clk);
        req_valid = 1; req_addr = 32'h0000_0500;
        @(negedge clk);
        req_valid = 0; m_axi_arready = 1;
        @(negedge clk);
        m_axi_arready = 0;
        for (int b = 0; b < 2; b++) begin
            m_axi_rvalid = 1; m_axi_rdata = 32'hBAD0 + b; m_axi_rlast = 0;
            @(negedge clk);
        end
        m_axi_rvalid = 0;
        #2 rst_n = 0;
        #1;
        chk("mid_rst_req_ready", 128'(req_ready), 128'(1));
        chk("mid_rst_arvalid", 128'(m_axi_arvalid), 128'(0));
        chk("mid_rst_rready", 128'(m_axi_rready), 128'(0));
        chk("mid_rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("mid_rst_araddr", 128'(m_axi_araddr), 128'(0));
        chk("mid_rst_rdata", resp_rdata, 128'(0));
        @(negedge clk);
        rst_n = 1;
        do_fill(tbl[4], 0, 0, '0);

        // req_valid held through a fill: second request taken right after resp_valid
        rv = tbl[0];
        do_fill(rv, 0, 1, 32'h0000_0A7C);
        @(negedge clk);
        req_valid = 0;
        rv = tbl[2];
        rv.addr = 32'h0000_0A7C;
        rv = model(rv);
        do_fill(rv, 1, 0, '0);

        for (int i = 0; i < 8; i++) begin
            rv.addr = $urandom;
            for (int b = 0; b < LW; b++) begin
                rv.data[b] = $urandom;
                rv.resp[b] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                rv.last[b] = (b == LW-1);
            end
            if ($urandom_range(0, 3) == 0) rv.last[$urandom_range(0, LW-1)] ^= 1'b1;
            rv.ar_dly = $urandom_range(0, 3);
            rv.gap = $urandom_range(0, 2);
            rv = model(rv);
            do_fill(rv, 0, 0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
